// File: rtl/mux4_pkg.sv
// mux4_pkg: shared constants for the 4:1 datapath word multiplexer.
//   MUX_DATA_WIDTH  - default word width for mux4 and mux4_if.
//   MUX_SELECT_SIZE - select code width; the mux only supports 2.
//   mux_sel_e       - select encodings, shared with datapath control logic.
package mux4_pkg;

  localparam int unsigned MUX_DATA_WIDTH  = 16;
  localparam int unsigned MUX_SELECT_SIZE = 2;

  typedef enum logic [1:0] {
    MUX_SEL_0 = 2'b00,
    MUX_SEL_1 = 2'b01,
    MUX_SEL_2 = 2'b10,
    MUX_SEL_3 = 2'b11
  } mux_sel_e;

endpackage

// File: rtl/mux4_if.sv
// mux4_if: signal bundle between a datapath controller and mux4.
//   select_i           - source select code (driven by master).
//   data0_i..data3_i   - candidate source words (driven by master).
//   data_o             - combinational selected word (driven by slave).
//   data_q_o           - data_o registered on the clock (driven by slave).
//   select_q_o         - select_i registered on the clock (driven by slave).
interface mux4_if
  import mux4_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = MUX_DATA_WIDTH,
  parameter int unsigned SELECT_SIZE = MUX_SELECT_SIZE
) ();

  logic [SELECT_SIZE-1:0] select_i;
  logic [DATA_WIDTH-1:0]  data0_i;
  logic [DATA_WIDTH-1:0]  data1_i;
  logic [DATA_WIDTH-1:0]  data2_i;
  logic [DATA_WIDTH-1:0]  data3_i;
  logic [DATA_WIDTH-1:0]  data_o;
  logic [DATA_WIDTH-1:0]  data_q_o;
  logic [SELECT_SIZE-1:0] select_q_o;

  modport master (
    output select_i, data0_i, data1_i, data2_i, data3_i,
    input  data_o, data_q_o, select_q_o
  );

  modport slave (
    input  select_i, data0_i, data1_i, data2_i, data3_i,
    output data_o, data_q_o, select_q_o
  );

endinterface

// File: rtl/mux4.sv
// mux4: 4:1 word multiplexer for datapath steering.
//   clk_i     - datapath clock; rising edge updates the registered outputs.
//   reset_ni  - asynchronous active-low reset of the registered outputs only.
//   bus       - mux4_if slave: select_i, data0_i..data3_i in;
//               data_o (combinational, zero latency), data_q_o and
//               select_q_o (one-cycle registered copies) out.
module mux4
  import mux4_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = MUX_DATA_WIDTH,
  parameter int unsigned SELECT_SIZE = MUX_SELECT_SIZE
) (
  input  logic   clk_i,
  input  logic   reset_ni,
  mux4_if.slave  bus
);

  if (SELECT_SIZE != 2) begin : g_select_size_check
    $error("mux4: SELECT_SIZE must be 2");
  end

  logic [DATA_WIDTH-1:0]  data_d;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [SELECT_SIZE-1:0] select_q;

  always_comb begin
    data_d = bus.data0_i;
    case (mux_sel_e'(bus.select_i))
      MUX_SEL_0: data_d = bus.data0_i;
      MUX_SEL_1: data_d = bus.data1_i;
      MUX_SEL_2: data_d = bus.data2_i;
      MUX_SEL_3: data_d = bus.data3_i;
      default:   data_d = bus.data0_i;
    endcase
`ifndef SYNTHESIS
    // An unknown select must show up as X rather than silently picking data0.
    if ($isunknown(bus.select_i)) data_d = 'x;
`endif
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      data_q   <= '0;
      select_q <= '0;
    end else begin
      data_q   <= data_d;
      select_q <= bus.select_i;
    end
  end

  assign bus.data_o     = data_d;
  assign bus.data_q_o   = data_q;
  assign bus.select_q_o = select_q;

endmodule

// File: tb/tb_mux4.sv
// tb_mux4: randomized scoreboard bench for mux4.
module tb_mux4;
  import mux4_pkg::*;

  localparam int unsigned DW = 16;

  logic clk;
  logic rst_n;

  mux4_if #(.DATA_WIDTH(DW), .SELECT_SIZE(2)) bus ();

  mux4 #(.DATA_WIDTH(DW), .SELECT_SIZE(2)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Reference model: source words as an array, registered copies as plain values.
  logic [DW-1:0] src [4];
  logic [1:0]    sel_m;
  logic [DW-1:0] exp_dq;
  logic [1:0]    exp_sq;

  function automatic logic [DW-1:0] pick(input logic [1:0] s);
    return src[s];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_dq = '0;
      exp_sq = 2'b00;
    end else begin
      exp_dq = pick(sel_m);
      exp_sq = sel_m;
    end
  end

  // Scoreboard
  typedef struct {
    int unsigned   sig;   // 0=data_o 1=data_q_o 2=select_q_o
    logic [DW-1:0] exp;
    string         name;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  function automatic logic [DW-1:0] actual(input int unsigned s);
    case (s)
      0:       return bus.data_o;
      1:       return bus.data_q_o;
      default: return {{(DW-2){1'b0}}, bus.select_q_o};
    endcase
  endfunction

  initial begin
    exp_t e;
    logic [DW-1:0] a;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        a = actual(e.sig);
        n_total++;
        if (a === e.exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", e.name, a, e.exp, $time);
      end
    end
  end

  task automatic expect_val(input int unsigned sig, input logic [DW-1:0] v, input string n);
    exp_t e;
    e.sig = sig; e.exp = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic strobe();
    -> chk_ev;
    #0;
  endtask

  task automatic drive(input logic [1:0] s, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    src[0] = d0; src[1] = d1; src[2] = d2; src[3] = d3; sel_m = s;
    bus.select_i = s;
    bus.data0_i = d0; bus.data1_i = d1; bus.data2_i = d2; bus.data3_i = d3;
  endtask

  task automatic check_comb(input string n);
    expect_val(0, pick(sel_m), n);
    strobe();
  endtask

  task automatic check_regs(input string n);
    expect_val(1, exp_dq, {n, "_dq"});
    expect_val(2, {{(DW-2){1'b0}}, exp_sq}, {n, "_sq"});
    strobe();
  endtask

  initial begin
    #200us;
    $display("FAIL timeout: simulation did not finish, got no summary expected summary");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] w;
    int unsigned   mode;
    rst_n = 1'b0;
    drive(2'b00, 16'h000A, 16'h00A0, 16'h0A00, 16'hA000);

    // Select decoding while held in reset: data_o must not depend on the clock.
    for (int unsigned s = 0; s < 4; s++) begin
      @(negedge clk); #1;
      drive(2'(s), 16'h000A, 16'h00A0, 16'h0A00, 16'hA000);
      #10;
      check_comb("sel_in_reset");
      expect_val(0, 16'h000A << (4 * s), "sel_const");
      expect_val(1, 16'h0000, "reset_dq");
      expect_val(2, 16'h0000, "reset_sq");
      strobe();
    end

    @(negedge clk); rst_n = 1'b1;

    // Randomized operation, including equal, all-ones and all-zero words.
    for (int unsigned i = 0; i < 150; i++) begin
      @(negedge clk); #1;
      mode = $urandom_range(0, 3);
      case (mode)
        0: drive(2'($urandom_range(0, 3)), DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
        1: begin w = DW'($urandom); drive(2'($urandom_range(0, 3)), w, w, w, w); end
        2: drive(2'($urandom_range(0, 3)), '1, '0, '1, '0);
        default: begin w = ($urandom_range(0, 1) == 1) ? '1 : '0;
                       drive(2'($urandom_range(0, 3)), w, w, w, w); end
      endcase
      #10;
      check_comb("rand_comb");
      @(posedge clk); #1;
      check_regs("rand_reg");
    end

    // Asynchronous reset mid-run with select=11.
    @(negedge clk); #1;
    drive(2'b11, 16'h000A, 16'h00A0, 16'h0A00, 16'hA000);
    @(posedge clk); #1;
    check_regs("pre_reset");
    #5 rst_n = 1'b0;
    #1;
    expect_val(1, 16'h0000, "async_reset_dq");
    expect_val(2, 16'h0000, "async_reset_sq");
    expect_val(0, 16'hA000, "async_reset_data_o");
    strobe();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    expect_val(1, 16'hA000, "post_reset_dq");
    expect_val(2, 16'h0003, "post_reset_sq");
    strobe();

    // data2 change with select=10 propagates without a clock; register follows next edge.
    @(negedge clk); #1;
    drive(2'b10, 16'h000A, 16'h00A0, 16'h0A00, 16'hA000);
    @(posedge clk); #1;
    @(negedge clk); #1;
    drive(2'b10, 16'h000A, 16'h00A0, 16'hFFFF, 16'hA000);
    #10;
    expect_val(0, 16'hFFFF, "data2_change_comb");
    expect_val(1, 16'h0A00, "data2_change_dq_hold");
    strobe();
    @(posedge clk); #1;
    expect_val(1, 16'hFFFF, "data2_change_dq");
    expect_val(2, 16'h0002, "data2_change_sq");
    strobe();

    #5;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
